// File: rtl/uart_tx_if.sv
// Host-side handshake bundle for the UART transmitter: parallel word in,
// serial line and frame status out.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 start;
  logic                 tx;
  logic                 busy;
  logic                 done;

  modport master (
    output data,
    output start,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  data,
    input  start,
    output tx,
    output busy,
    output done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// STOP_BITS stop bits; every bit lasts OVERSAMPLE ticks of the baud x16 clock.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic     tick,
  input  logic     reset,
  uart_tx_if.slave bus
);

  localparam int BCW = $clog2(DATA_BITS + 1);

  localparam logic [3:0]     TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);
  localparam logic           PAR_ODD   = (PARITY == 2);
  localparam logic           PAR_EN    = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             tick_cnt_q, tick_cnt_d;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   bit_end;

  always_ff @(posedge tick or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    done_d     = 1'b0;
    bit_end    = (tick_cnt_q == TICK_LAST);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          shreg_d    = bus.data;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          par_d      = 1'b0;
          state_d    = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = S_DATA;
        end else begin
          tick_cnt_d = tick_cnt_q + 4'd1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          tick_cnt_d = '0;
          shreg_d    = {1'b0, shreg_q[DATA_BITS-1:1]};
          par_d      = par_q ^ shreg_q[0];
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + 4'd1;
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = S_STOP;
        end else begin
          tick_cnt_d = tick_cnt_q + 4'd1;
        end
      end

      S_STOP: begin
        // The bit counter is reused to count stop bits.
        if (bit_end) begin
          tick_cnt_d = '0;
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            state_d   = S_IDLE;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + 4'd1;
        end
      end

      default: begin
        state_d    = S_IDLE;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase

    // Line level is decoded from the next state so tx comes straight off a flop.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d ^ PAR_ODD;
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameter sets side by side, table vectors, corner-case
// sequences and random frames checked against a bit-list frame model.
module tb_uart_tx;

  localparam int OS = 16;

  logic tick;
  logic reset;

  logic [3:0] start_v;
  logic [8:0] data_v [4];
  logic [3:0] tx_w, busy_w, done_w;

  int checks   = 0;
  int failures = 0;

  uart_tx_if #(.DATA_BITS(8)) if0 ();
  uart_tx_if #(.DATA_BITS(8)) if1 ();
  uart_tx_if #(.DATA_BITS(8)) if2 ();
  uart_tx_if #(.DATA_BITS(7)) if3 ();

  uart_tx #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1))
    dut0 (.tick(tick), .reset(reset), .bus(if0.slave));
  uart_tx #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(1), .STOP_BITS(1))
    dut1 (.tick(tick), .reset(reset), .bus(if1.slave));
  uart_tx #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(1))
    dut2 (.tick(tick), .reset(reset), .bus(if2.slave));
  uart_tx #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(2))
    dut3 (.tick(tick), .reset(reset), .bus(if3.slave));

  assign if0.start = start_v[0];
  assign if1.start = start_v[1];
  assign if2.start = start_v[2];
  assign if3.start = start_v[3];
  assign if0.data  = data_v[0][7:0];
  assign if1.data  = data_v[1][7:0];
  assign if2.data  = data_v[2][7:0];
  assign if3.data  = data_v[3][6:0];

  assign tx_w   = {if3.tx,   if2.tx,   if1.tx,   if0.tx};
  assign busy_w = {if3.busy, if2.busy, if1.busy, if0.busy};
  assign done_w = {if3.done, if2.done, if1.done, if0.done};

  initial tick = 1'b0;
  always #5 tick = ~tick;

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  function automatic int nb_of(input int d);
    return (d == 3) ? 7 : 8;
  endfunction

  function automatic int par_of(input int d);
    return (d == 1) ? 1 : ((d == 2) ? 2 : 0);
  endfunction

  function automatic int sb_of(input int d);
    return (d == 3) ? 2 : 1;
  endfunction

  // Frame as a list of line levels, one per bit period; unwritten tail stays high.
  function automatic logic [15:0] model_frame(input int d, input logic [8:0] w, output int n);
    logic [15:0] v;
    int ones;
    v    = '1;
    n    = 0;
    ones = 0;
    v[n] = 1'b0;
    n++;
    for (int i = 0; i < nb_of(d); i++) begin
      v[n] = w[i];
      if (w[i]) ones++;
      n++;
    end
    if (par_of(d) != 0) begin
      v[n] = (par_of(d) == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      n++;
    end
    n += sb_of(d);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge tick);
    #1;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (busy_w[d] !== 1'b0 && n < 400) begin
      cyc();
      n++;
    end
    if (n >= 400) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic check_idle(input int d, input int ncyc, input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < ncyc; i++) begin
      cyc();
      if (done_w[d] !== 1'b0 || busy_w[d] !== 1'b0 || tx_w[d] !== 1'b1) bad++;
    end
    check(name, bad, 0);
  endtask

  // Sends one word on DUT d and checks every tick of the frame against the model.
  // poke_at >= 0 re-requests with different data at that tick; hold keeps start high.
  task automatic run_frame(input int d, input logic [8:0] w, input bit hold, input int poke_at,
                           output logic [15:0] obs, output int busy_cnt);
    logic [15:0] expv;
    logic [8:0]  dec;
    int nbits, nticks, bad, first_bad;
    expv = model_frame(d, w, nbits);
    nticks = nbits * OS;
    wait_idle(d);
    data_v[d]  = w;
    start_v[d] = 1'b1;
    cyc();
    if (!hold) start_v[d] = 1'b0;
    bad = 0; first_bad = -1; busy_cnt = 0; obs = '0;
    for (int k = 0; k < nticks; k++) begin
      if (k > 0) cyc();
      if (tx_w[d] !== expv[k / OS] || busy_w[d] !== 1'b1 || done_w[d] !== 1'b0) begin
        if (bad == 0) first_bad = k;
        bad++;
      end
      if (busy_w[d] === 1'b1) busy_cnt++;
      if (k % OS == OS / 2) obs[k / OS] = tx_w[d];
      if (poke_at >= 0 && k == poke_at) begin
        start_v[d] = 1'b1;
        data_v[d]  = ~w;
      end
      if (poke_at >= 0 && k == poke_at + 1) start_v[d] = 1'b0;
    end
    if (bad != 0) $display("  dut%0d word %0h first bad tick %0d", d, w, first_bad);
    check($sformatf("frame_samples_bad_dut%0d", d), bad, 0);
    dec = '0;
    for (int i = 0; i < nb_of(d); i++) dec[i] = obs[1 + i];
    check($sformatf("rx_decode_dut%0d", d), int'(dec), int'(w));
    cyc();
    check($sformatf("done_pulse_dut%0d", d), int'({done_w[d], busy_w[d], tx_w[d]}), 3'b101);
    if (!hold) begin
      cyc();
      check($sformatf("after_done_dut%0d", d), int'({done_w[d], busy_w[d], tx_w[d]}), 3'b001);
    end
  endtask

  typedef struct {
    int          dut;
    logic [8:0]  data;
    int          exp_nbits;
    logic [15:0] exp_bits;
  } vec_t;

  vec_t        tbl [4];
  logic [15:0] obs;
  int          bc;

  initial begin
    tbl[0] = '{dut: 0, data: 9'h0A5, exp_nbits: 10, exp_bits: 16'h034A};
    tbl[1] = '{dut: 1, data: 9'h007, exp_nbits: 11, exp_bits: 16'h060E};
    tbl[2] = '{dut: 2, data: 9'h007, exp_nbits: 11, exp_bits: 16'h040E};
    tbl[3] = '{dut: 3, data: 9'h000, exp_nbits: 10, exp_bits: 16'h0300};

    reset   = 1'b0;
    start_v = '0;
    for (int i = 0; i < 4; i++) data_v[i] = '0;
    repeat (3) cyc();
    for (int i = 0; i < 4; i++)
      check($sformatf("reset_state_dut%0d", i), int'({tx_w[i], busy_w[i], done_w[i]}), 3'b100);
    @(negedge tick);
    reset = 1'b1;

    // Table vectors: fixed bit patterns and frame lengths.
    for (int i = 0; i < 4; i++) begin
      run_frame(tbl[i].dut, tbl[i].data, 1'b0, -1, obs, bc);
      check($sformatf("tbl_len_%0d", i), bc, tbl[i].exp_nbits * OS);
      check($sformatf("tbl_bits_%0d", i),
            int'(obs & ((16'd1 << tbl[i].exp_nbits) - 16'd1)), int'(tbl[i].exp_bits));
    end

    // Request while busy, with changed data, is ignored.
    run_frame(0, 9'h000, 1'b0, 40, obs, bc);
    check_idle(0, 20, "ignored_start_no_second_frame");

    // start held high: back-to-back frames one idle tick apart.
    run_frame(0, 9'h055, 1'b1, -1, obs, bc);
    run_frame(0, 9'h055, 1'b1, -1, obs, bc);
    start_v[0] = 1'b0;
    check_idle(0, 5, "hold_release_idle");

    // Reset mid-frame aborts immediately with no done.
    data_v[0]  = 9'h0C3;
    start_v[0] = 1'b1;
    cyc();
    start_v[0] = 1'b0;
    repeat (70) cyc();
    reset = 1'b0;
    #1;
    check("rst_abort_tx_busy_done", int'({tx_w[0], busy_w[0], done_w[0]}), 3'b100);
    repeat (3) cyc();
    check("rst_hold_all", int'({tx_w, busy_w, done_w}), int'({4'hF, 4'h0, 4'h0}));
    @(negedge tick);
    reset = 1'b1;
    check_idle(0, 4, "post_rst_idle");
    run_frame(0, 9'h03C, 1'b0, -1, obs, bc);

    // Random frames across all parameter sets.
    for (int i = 0; i < 24; i++) begin
      int d, nb, pk;
      logic [8:0] w;
      d  = $urandom_range(0, 3);
      nb = nb_of(d);
      w  = 9'($urandom) & 9'((1 << nb) - 1);
      pk = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 150) : -1;
      run_frame(d, w, 1'b0, pk, obs, bc);
      repeat ($urandom_range(0, 3)) cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
